// File: rtl/ysyx_040729_pkg.sv
// Shared definitions for the ysyx_040729 execute-stage divider: FSM encoding,
// fixup control bundle and the special-case constants.
package ysyx_040729_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic w;
    logic neg_q;
    logic neg_r;
  } div_ctl_t;

  // Constants are built at the widest supported width and sliced by users.
  localparam int DIV_MAX_W = 128;
  localparam logic [DIV_MAX_W-1:0] DIV_ALL_ONES = '1;

  function automatic logic [DIV_MAX_W-1:0] div_most_neg(input int w);
    return {{(DIV_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/ysyx_040729_exe_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift out one quotient bit.
module ysyx_040729_exe_div_iter #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0]   part;
  logic [W+1:0] diff;

  always_comb begin
    part  = {rem_i, quo_i[W-1]};
    diff  = {1'b0, part} - {2'b00, dvs_i};
    // Extra top bit is the borrow: set means the divisor did not fit.
    rem_o = diff[W+1] ? part[W-1:0] : diff[W-1:0];
    quo_o = {quo_i[W-2:0], ~diff[W+1]};
  end

endmodule

// File: rtl/ysyx_040729_exe_div_unit.sv
// Multi-cycle restoring divider (1 bit/cycle) with signed, unsigned and
// half-width (W) modes; divide-by-zero and signed overflow finish in one cycle.
module ysyx_040729_exe_div_unit
  import ysyx_040729_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int WORD_MODE_EN = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  div_signed,
  input  logic                  divw,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int DW = DATA_WIDTH;
  localparam int H  = DW / 2;
  localparam int CW = $clog2(DW);

  localparam logic [DIV_MAX_W-1:0] MN_FULL = div_most_neg(DW);
  localparam logic [DIV_MAX_W-1:0] MN_HALF = div_most_neg(H);
  localparam logic [DW-1:0] ONES = DIV_ALL_ONES[DW-1:0];
  localparam logic [DW-1:0] MN   = MN_FULL[DW-1:0];
  localparam logic [DW-1:0] MN_W = {{H{1'b1}}, MN_HALF[H-1:0]};
  localparam logic [CW-1:0] L_FULL = CW'(DW - 1);
  localparam logic [CW-1:0] L_HALF = CW'(H - 1);

  // W-mode results are sign-extended from the half-width MSB.
  function automatic logic [DW-1:0] fit(input logic [DW-1:0] x, input logic w);
    return w ? {{H{x[H-1]}}, x[H-1:0]} : x;
  endfunction

  div_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  div_ctl_t       ctl_q, ctl_d;

  logic           accept, w_in, a_neg, b_neg, div_zero, ovf, special;
  logic [DW-1:0]  a_ext, b_ext, a_mag, b_mag, it_rem, it_quo, fix_q, fix_r;

  assign accept = in_valid & in_ready & ~flush;
  assign w_in   = (WORD_MODE_EN != 0) ? divw : 1'b0;

  always_comb begin
    a_ext = dividend;
    b_ext = divisor;
    if (w_in) begin
      a_ext = div_signed ? fit(dividend, 1'b1) : {{H{1'b0}}, dividend[H-1:0]};
      b_ext = div_signed ? fit(divisor, 1'b1)  : {{H{1'b0}}, divisor[H-1:0]};
    end
  end

  assign a_neg    = div_signed & a_ext[DW-1];
  assign b_neg    = div_signed & b_ext[DW-1];
  assign a_mag    = a_neg ? -a_ext : a_ext;
  assign b_mag    = b_neg ? -b_ext : b_ext;
  assign div_zero = (b_ext == '0);
  assign ovf      = div_signed & (a_ext == (w_in ? MN_W : MN)) & (b_ext == ONES);
  assign special  = div_zero | ovf;

  assign fix_q = ctl_q.neg_q ? -quo_q : quo_q;
  assign fix_r = ctl_q.neg_r ? -rem_q : rem_q;

  ysyx_040729_exe_div_iter #(.W(DW)) u_iter (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (it_rem),
    .quo_o (it_quo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (accept) state_d = special ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == '0) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: if (out_ready) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    ctl_d = ctl_q;
    unique case (state_q)
      DIV_IDLE: if (accept) begin
        ctl_d = '{w: w_in, neg_q: a_neg ^ b_neg, neg_r: a_neg};
        dvs_d = b_mag;
        if (div_zero) begin
          quo_d = ONES;
          rem_d = fit(a_ext, w_in);
        end else if (ovf) begin
          quo_d = a_ext;
          rem_d = '0;
        end else begin
          // W mode parks the magnitude in the upper half so the MSB-first
          // shift consumes exactly H dividend bits.
          quo_d = w_in ? (a_mag << H) : a_mag;
          rem_d = '0;
          cnt_d = w_in ? L_HALF : L_FULL;
        end
      end
      DIV_CALC: begin
        rem_d = it_rem;
        quo_d = it_quo;
        cnt_d = cnt_q - 1'b1;
      end
      DIV_FIX: begin
        quo_d = fit(fix_q, ctl_q.w);
        rem_d = fit(fix_r, ctl_q.w);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == DIV_IDLE) & ~reset;
    out_valid = (state_q == DIV_DONE) & ~reset;
    quotient  = out_valid ? quo_q : '0;
    remainder = out_valid ? rem_q : '0;
  end

endmodule

// File: tb/tb_ysyx_040729_exe_div_unit.sv
// Directed plus randomized checks of the divider against an arithmetic
// reference model (native SystemVerilog / and % on the in-width operands).
module tb_ysyx_040729_exe_div_unit;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, div_signed, divw;
  logic        out_valid, out_ready;
  logic [63:0] dividend, divisor, quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ysyx_040729_exe_div_unit #(.DATA_WIDTH(64), .WORD_MODE_EN(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_signed (div_signed),
    .divw       (divw),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic w,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output int lat);
    if (w) begin
      logic [31:0] x, y, qq, rr;
      x = a[31:0];
      y = b[31:0];
      lat = 34;
      if (y == 0) begin
        qq = '1; rr = x; lat = 1;
      end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        qq = x; rr = 0; lat = 1;
      end else if (s) begin
        qq = $signed(x) / $signed(y);
        rr = $signed(x) % $signed(y);
      end else begin
        qq = x / y;
        rr = x % y;
      end
      q = {{32{qq[31]}}, qq};
      r = {{32{rr[31]}}, rr};
    end else begin
      lat = 66;
      if (b == 0) begin
        q = '1; r = a; lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 0; lat = 1;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Starts and ends on a falling edge; returns when out_valid is seen.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic w,
                       output logic [63:0] q_o, output logic [63:0] r_o);
    logic [63:0] eq, er;
    int elat, lat, t;
    ref_div(a, b, s, w, eq, er, elat);
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clock); t++; end
    chk({tag, ".ready"}, {63'b0, in_ready}, 64'd1);
    dividend = a; divisor = b; div_signed = s; divw = w; in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      in_valid   = 1'b0;
      dividend   = {$urandom, $urandom};
      divisor    = {$urandom, $urandom};
      div_signed = 1'($urandom);
      divw       = 1'($urandom);
    end while (!out_valid && lat < 200);
    chk({tag, ".lat"}, 64'(lat), 64'(elat));
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    q_o = quotient;
    r_o = remainder;
  endtask

  initial begin
    logic [63:0] q, r, q0, r0, a, b;
    logic seen;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0; div_signed = 1'b0; divw = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst.in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst.out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst.quotient", quotient, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst.in_ready", {63'b0, in_ready}, 64'd1);

    do_op("neg7by2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, q, r);
    chk("neg7by2.qc", q, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("neg7by2.rc", r, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("divzero", 64'h1234, 64'd0, 1'b0, 1'b0, q, r);
    chk("divzero.qc", q, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divzero.rc", r, 64'h1234);
    do_op("ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, q, r);
    chk("ovf.qc", q, 64'h8000_0000_0000_0000);
    chk("ovf.rc", r, 64'd0);
    do_op("divw", 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 1'b1, 1'b1, q, r);
    chk("divw.qc", q, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("divw.rc", r, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("ovfw", 64'h5555_5555_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, q, r);
    do_op("uzerow", 64'h1111_1111_8000_0005, 64'hABCD_0000_0000_0000, 1'b0, 1'b1, q, r);

    // Flush during CALC.
    @(negedge clock);
    dividend = 64'd1000; divisor = 64'd3; div_signed = 1'b0; divw = 1'b0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush.in_ready", {63'b0, in_ready}, 64'd1);
    chk("flush.out_valid", {63'b0, out_valid}, 64'd0);
    seen = 1'b0;
    repeat (80) begin @(negedge clock); if (out_valid) seen = 1'b1; end
    chk("flush.no_valid", {63'b0, seen}, 64'd0);
    do_op("after_flush", 64'd100, 64'd7, 1'b0, 1'b0, q, r);
    chk("after_flush.qc", q, 64'd14);
    chk("after_flush.rc", r, 64'd2);

    // Flush in the same cycle as a special-case request must block the accept.
    @(negedge clock);
    dividend = 64'd5; divisor = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc.out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_acc.in_ready", {63'b0, in_ready}, 64'd1);

    // Back-pressure in DONE; a pending request must not be taken.
    out_ready = 1'b0;
    do_op("hold", 64'd123456789, 64'd1000, 1'b0, 1'b0, q0, r0);
    in_valid = 1'b1; dividend = 64'd9; divisor = 64'd0;
    repeat (5) begin
      @(negedge clock);
      chk("hold.out_valid", {63'b0, out_valid}, 64'd1);
      chk("hold.in_ready", {63'b0, in_ready}, 64'd0);
      chk("hold.q", quotient, q0);
      chk("hold.r", remainder, r0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    chk("release.in_ready", {63'b0, in_ready}, 64'd1);
    chk("release.out_valid", {63'b0, out_valid}, 64'd0);
    chk("release.q", quotient, 64'd0);

    // Flush in DONE.
    out_ready = 1'b0;
    do_op("flush_done", 64'd77, 64'd5, 1'b1, 1'b0, q, r);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0; out_ready = 1'b1;
    chk("flush_done.out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_done.in_ready", {63'b0, in_ready}, 64'd1);

    // Reset mid-operation discards the result.
    dividend = 64'd999; divisor = 64'd4; div_signed = 1'b0; divw = 1'b0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst.out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst.in_ready", {63'b0, in_ready}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst.post_ready", {63'b0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (80) begin @(negedge clock); if (out_valid) seen = 1'b1; end
    chk("midrst.no_valid", {63'b0, seen}, 64'd0);

    // Randomized operands with bias toward the boundary cases.
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      case ($urandom_range(0, 9))
        0: b = 64'd0;
        1: b = '1;
        2: b = 64'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) a = {32'($urandom), 32'h8000_0000};
      if ($urandom_range(0, 7) == 0) a = 64'h8000_0000_0000_0000;
      do_op("rand", a, b, 1'($urandom), 1'($urandom), q, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_040729_exe_div_unit.md
YSYX_040729_EXE_DIV_UNIT -- requirements
Module: ysyx_040729_exe_div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, giving the operand/result width (even, >=8).
REQ-002 SHALL have parameter WORD_MODE_EN, default 1, enabling the half-width (W) operation mode.
REQ-003 SHALL have port clock  input  1  single clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  abort any operation; unit returns to IDLE next cycle.
REQ-006 SHALL have port in_valid  input  1  request strobe.
REQ-007 SHALL have port in_ready  output  1  high only in IDLE; a request is accepted when in_valid & in_ready & ~flush.
REQ-008 SHALL have port dividend  input  DATA_WIDTH  raw rs1 value.
REQ-009 SHALL have port divisor  input  DATA_WIDTH  raw rs2 value.
REQ-010 SHALL have port div_signed  input  1  1 = signed (div/rem), 0 = unsigned.
REQ-011 SHALL have port divw  input  1  1 = W mode on the low DATA_WIDTH/2 bits; ignored when WORD_MODE_EN=0.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result when out_valid & out_ready.
REQ-014 SHALL have port quotient  output  DATA_WIDTH  final signed/unsigned quotient.
REQ-015 SHALL have port remainder  output  DATA_WIDTH  final remainder, with the sign of the dividend.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, FIX, DONE: IDLE->CALC on accept; IDLE->DONE on accept of a special case; CALC->FIX when the iteration counter expires; FIX->DONE; DONE->IDLE on out_valid & out_ready.
REQ-017 SHALL register the operands, latch div_signed/divw, and convert to magnitudes on accept, so input changes after accept have no effect.
REQ-018 SHALL, in W mode, use only bits [DATA_WIDTH/2-1:0] of each operand, ignore the upper bits, and sign-extend both results from bit DATA_WIDTH/2-1.
REQ-019 SHALL perform restoring division at 1 quotient bit per cycle, with L = DATA_WIDTH cycles in CALC (DATA_WIDTH/2 in W mode).
REQ-020 SHALL, in FIX, negate the quotient when signed and the operand signs differ, and negate the remainder when signed and the dividend is negative.
REQ-021 SHALL drive out_valid in the cycle accept+L+2 for normal operations.
REQ-022 SHALL drive out_valid in the cycle accept+1 for the special cases:
  - divisor==0: quotient = all ones, remainder = dividend (in-width).
  - signed, dividend = most negative, divisor = -1: quotient = dividend, remainder = 0.
REQ-023 SHALL hold quotient, remainder and out_valid stable in DONE until out_ready is high; the unit SHALL NOT accept a new request while in DONE.
REQ-024 SHALL drive quotient/remainder to 0 whenever out_valid is low.
REQ-025 SHALL, on flush in any state (including DONE, and in the same cycle as in_valid), go to IDLE, drop out_valid next cycle, and drop any in-flight result; flush overrides accept.
REQ-026 SHALL allow back-to-back operation: with out_ready held high, DONE->IDLE, and in_ready is high the following cycle.

Reset
REQ-027 SHALL, while reset is high at a clock edge, enter IDLE, clear the counter and data registers, and force out_valid=0, in_ready=0 during reset and in_ready=1 the cycle after.
REQ-028 SHALL give reset priority over flush and accept; reset mid-operation SHALL discard the result silently.

Structure
REQ-029 SHALL place the FSM state encoding and the special-case constants (all-ones, most-negative) in the shared ysyx_040729 package.
REQ-030 SHALL use one sub-module, ysyx_040729_exe_div_iter, for the combinational single-step subtract/shift datapath; the FSM, counter and sign fixup stay in the top module.

Verification
REQ-031 SHALL cover: DATA_WIDTH=64, signed, -7 / 2 -> quotient 0xFFFFFFFFFFFFFFFD, remainder 0xFFFFFFFFFFFFFFFF, out_valid at accept+66.
REQ-032 SHALL cover: unsigned 0x1234 / 0 -> quotient 0xFFFFFFFFFFFFFFFF, remainder 0x1234, out_valid at accept+1.
REQ-033 SHALL cover: signed 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> quotient 0x8000000000000000, remainder 0, out_valid at accept+1.
REQ-034 SHALL cover: divw signed, dividend 0xDEADBEEFFFFFFFF9, divisor 0x1234567800000002 -> quotient 0xFFFFFFFFFFFFFFFD, remainder 0xFFFFFFFFFFFFFFFF, out_valid at accept+34.
REQ-035 SHALL cover: flush at CALC cycle 10 -> out_valid never rises, in_ready=1 next cycle, and a subsequent 100/7 gives 14 rem 2.
REQ-036 SHALL cover: out_ready low for 5 cycles in DONE -> result held stable and in_ready=0 throughout, IDLE the cycle after out_ready rises.
